// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the multi-port register file: the controller state
// encoding and the default geometry (entries, width, port counts).
// ---------------------------------------------------------------------------
package regfile_pkg;

    localparam int DEF_M  = 32;   // entries
    localparam int DEF_N  = 32;   // data width
    localparam int DEF_NR = 2;    // read ports
    localparam int DEF_NW = 1;    // write ports

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_mp_core.sv
// ---------------------------------------------------------------------------
// regfile_mp_core
// Storage array with the clear/write mux. A clear request has priority over
// the write ports; among write ports the higher index wins on an address
// collision because its assignment is issued last.
//
// Ports
//   clk        : clock, rising edge
//   i_clr      : zero the entry at i_clr_addr this edge
//   i_clr_addr : entry being cleared
//   i_we       : per-port write enable (already qualified by the controller)
//   i_wa       : per-port write address
//   i_wd       : per-port write data
//   o_mem      : full array contents, read combinationally by the top
// ---------------------------------------------------------------------------
import regfile_pkg::*;

module regfile_mp_core #(
    parameter int M        = DEF_M,
    parameter int N        = DEF_N,
    parameter int NW       = DEF_NW,
    parameter int ZERO_REG = 0,
    parameter int AW       = $clog2(M)
) (
    input  logic                   clk,
    input  logic                   i_clr,
    input  logic [AW-1:0]          i_clr_addr,
    input  logic [NW-1:0]          i_we,
    input  logic [NW-1:0][AW-1:0]  i_wa,
    input  logic [NW-1:0][N-1:0]   i_wd,
    output logic [M-1:0][N-1:0]    o_mem
);

    logic [M-1:0][N-1:0] r_mem;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_mem[i_clr_addr] <= '0;
        end else begin
            for (int j = 0; j < NW; j++) begin
                // entry 0 never takes data when it is the hardwired zero
                if (i_we[j] && !((ZERO_REG != 0) && (i_wa[j] == '0))) begin
                    r_mem[i_wa[j]] <= i_wd[j];
                end
            end
        end
    end

    assign o_mem = r_mem;

endmodule

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
// Multi-port register file with registered read ports, optional write-first
// bypass, optional hardwired-zero entry 0, and a post-reset clear sequence
// that zeroes one entry per cycle before the file accepts writes.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   CLEAR | zeroing entry r_cnt each edge; busy=1, writes ignored, dout=0
//   RUN   | normal operation; busy=0
//
// Ports
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, restarts the clear sequence
//   we   : per-port write enable
//   rw   : per-port write address
//   din  : per-port write data
//   r    : per-port read address
//   dout : per-port read data, one cycle after the address
//   busy : high while the clear sequence runs
// ---------------------------------------------------------------------------
import regfile_pkg::*;

module regfile_mp #(
    parameter int M        = DEF_M,
    parameter int N        = DEF_N,
    parameter int NR       = DEF_NR,
    parameter int NW       = DEF_NW,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NW-1:0]                 we,
    input  logic [NW-1:0][$clog2(M)-1:0]  rw,
    input  logic [NW-1:0][N-1:0]          din,
    input  logic [NR-1:0][$clog2(M)-1:0]  r,
    output logic [NR-1:0][N-1:0]          dout,
    output logic                          busy
);

    localparam int            AW   = $clog2(M);
    localparam logic [AW-1:0] LAST = AW'(M - 1);

    state_t               r_state;
    logic [AW-1:0]        r_cnt;
    logic                 r_busy;
    logic [NR-1:0][N-1:0] r_dout;

    logic                 w_clr;
    logic [NW-1:0]        w_we;
    logic [M-1:0][N-1:0]  w_mem;
    logic [NR-1:0][N-1:0] w_rd;

    // Writes only land in RUN; a reset edge never stores anything.
    assign w_we  = (r_busy || rst) ? '0 : we;
    assign w_clr = (r_state == CLEAR) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_state <= RUN;
                        r_busy  <= 1'b0;
                    end
                end
                RUN: begin
                    r_busy <= 1'b0;
                end
                default: begin
                    r_state <= CLEAR;
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    regfile_mp_core #(
        .M        (M),
        .N        (N),
        .NW       (NW),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_core (
        .clk        (clk),
        .i_clr      (w_clr),
        .i_clr_addr (r_cnt),
        .i_we       (w_we),
        .i_wa       (rw),
        .i_wd       (din),
        .o_mem      (w_mem)
    );

    // Read mux: array contents, then same-cycle write data when bypassing
    // (later port overrides earlier), then the hardwired zero on top.
    always_comb begin
        w_rd = '0;
        for (int k = 0; k < NR; k++) begin
            w_rd[k] = w_mem[r[k]];
            if (BYPASS != 0) begin
                for (int j = 0; j < NW; j++) begin
                    if (w_we[j] && (rw[j] == r[k])) begin
                        w_rd[k] = din[j];
                    end
                end
            end
            if ((ZERO_REG != 0) && (r[k] == '0)) begin
                w_rd[k] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || r_busy) begin
            r_dout <= '0;
        end else begin
            r_dout <= w_rd;
        end
    end

    assign dout = r_dout;
    assign busy = r_busy;

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [1:0]      we;
    logic [1:0][4:0] rw;
    logic [1:0][31:0] din;
    logic [1:0][4:0] r;

    logic [1:0][31:0] dout_a, dout_b;
    logic             busy_a, busy_b;

    // A: write-first, no zero register.  B: read-first, entry 0 hardwired.
    regfile_mp #(.M(32), .N(32), .NR(2), .NW(2), .BYPASS(1), .ZERO_REG(0)) u_dut_a (
        .clk(clk), .rst(rst), .we(we), .rw(rw), .din(din), .r(r),
        .dout(dout_a), .busy(busy_a)
    );

    regfile_mp #(.M(32), .N(32), .NR(2), .NW(2), .BYPASS(0), .ZERO_REG(1)) u_dut_b (
        .clk(clk), .rst(rst), .we(we), .rw(rw), .din(din), .r(r),
        .dout(dout_b), .busy(busy_b)
    );

    typedef struct packed {
        logic             busy;
        logic [1:0][31:0] d;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int total = 0;
    int bad   = 0;

    // Reference model: contents, and how many clear cycles remain.
    logic [31:0] mem [2][32];
    int          clr_left [2];
    int          cfg_bypass [2] = '{1, 0};
    int          cfg_zreg   [2] = '{0, 1};

    task automatic chk(input string nm, input int di, input int k,
                       input logic [31:0] got, input logic [31:0] ex);
        total++;
        if (got !== ex) begin
            bad++;
            $display("FAIL %s dut%0d port%0d got=%h expected=%h t=%0t", nm, di, k, got, ex, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            chk("busy", 0, 0, {31'd0, busy_a}, {31'd0, e.busy});
            for (int k = 0; k < 2; k++) chk("dout", 0, k, dout_a[k], e.d[k]);
        end
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            chk("busy", 1, 0, {31'd0, busy_b}, {31'd0, e.busy});
            for (int k = 0; k < 2; k++) chk("dout", 1, k, dout_b[k], e.d[k]);
        end
    end

    // Drive one cycle, predict the outputs after the edge, queue them.
    task automatic step(input logic i_rst, input logic [1:0] i_we,
                        input logic [1:0][4:0] i_rw, input logic [1:0][31:0] i_din,
                        input logic [1:0][4:0] i_r);
        exp_t e [2];
        rst = i_rst; we = i_we; rw = i_rw; din = i_din; r = i_r;
        for (int d = 0; d < 2; d++) begin
            e[d] = '0;
            if (i_rst) begin
                clr_left[d] = 32;
                for (int a = 0; a < 32; a++) mem[d][a] = '0;
                e[d].busy = 1'b1;
            end else if (clr_left[d] > 0) begin
                clr_left[d]--;
                e[d].busy = (clr_left[d] > 0);
            end else begin
                for (int k = 0; k < 2; k++) begin
                    e[d].d[k] = mem[d][i_r[k]];
                    if (cfg_bypass[d] != 0)
                        for (int j = 0; j < 2; j++)
                            if (i_we[j] && i_rw[j] == i_r[k]) e[d].d[k] = i_din[j];
                    if (cfg_zreg[d] != 0 && i_r[k] == 5'd0) e[d].d[k] = '0;
                end
                for (int j = 0; j < 2; j++)
                    if (i_we[j] && !(cfg_zreg[d] != 0 && i_rw[j] == 5'd0))
                        mem[d][i_rw[j]] = i_din[j];
            end
        end
        @(posedge clk);
        q_a.push_back(e[0]);
        q_b.push_back(e[1]);
        #1;
    endtask

    function automatic logic [4:0] pick_addr();
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 3));
        return 5'($urandom_range(0, 31));
    endfunction

    task automatic idle(input logic [4:0] a0, input logic [4:0] a1);
        step(1'b0, 2'b00, '0, '0, {a1, a0});
    endtask

    // After a reset step, count cycles until busy drops (bounded).
    task automatic measure_busy(input string nm);
        int n = 0;
        while (busy_a && n < 100) begin
            idle(pick_addr(), pick_addr());
            n++;
        end
        total++;
        if (n != 32) begin
            bad++;
            $display("FAIL %s busy_cycles got=%0d expected=32", nm, n);
        end
    endtask

    task automatic read_all();
        for (int a = 0; a < 32; a++) idle(5'(a), 5'(31 - a));
    endtask

    initial begin
        logic [1:0]       t_we;
        logic [1:0][4:0]  t_rw;
        logic [1:0][31:0] t_din;
        logic [1:0][4:0]  t_r;

        rst = 1'b1; we = '0; rw = '0; din = '0; r = '0;
        clr_left[0] = 0; clr_left[1] = 0;

        // single-cycle reset pulse, then the clear sequence
        step(1'b1, '0, '0, '0, '0);
        measure_busy("reset");
        read_all();

        // basic write/read
        step(1'b0, 2'b01, {5'd0, 5'd5}, {32'd0, 32'hDEADBEEF}, {5'd9, 5'd9});
        idle(5'd5, 5'd5);

        // same-cycle bypass on read port 1
        step(1'b0, 2'b01, {5'd0, 5'd7}, {32'd0, 32'h1234}, {5'd7, 5'd0});
        idle(5'd7, 5'd7);

        // write conflict, then a same-cycle conflict under bypass
        step(1'b0, 2'b11, {5'd3, 5'd3}, {32'hB, 32'hA}, {5'd1, 5'd2});
        idle(5'd3, 5'd3);
        step(1'b0, 2'b11, {5'd4, 5'd4}, {32'h22, 32'h11}, {5'd4, 5'd4});
        idle(5'd4, 5'd4);

        // zero register, with same-cycle read of entry 0
        step(1'b0, 2'b01, {5'd0, 5'd0}, {32'd0, 32'hFFFF}, {5'd0, 5'd0});
        idle(5'd0, 5'd0);

        // reset at clear cycle 10; writes during the restarted clear are lost
        step(1'b1, '0, '0, '0, '0);
        for (int i = 0; i < 10; i++) idle(pick_addr(), pick_addr());
        step(1'b1, 2'b11, {5'd6, 5'd5}, {32'h66, 32'h55}, '0);
        begin
            int n = 0;
            while (busy_a && n < 100) begin
                step(1'b0, 2'b11, {pick_addr(), pick_addr()},
                     {32'($urandom), 32'($urandom)}, {pick_addr(), pick_addr()});
                n++;
            end
            total++;
            if (n != 32) begin
                bad++;
                $display("FAIL midclear busy_cycles got=%0d expected=32", n);
            end
        end
        read_all();

        // randomized traffic with occasional resets
        for (int i = 0; i < 2500; i++) begin
            t_we  = 2'($urandom);
            t_rw  = {pick_addr(), pick_addr()};
            t_din = {32'($urandom), 32'($urandom)};
            t_r   = {pick_addr(), pick_addr()};
            if ($urandom_range(0, 3) == 0) t_r[$urandom_range(0, 1)] = t_rw[$urandom_range(0, 1)];
            step(($urandom_range(0, 599) == 0), t_we, t_rw, t_din, t_r);
        end
        read_all();

        repeat (3) @(negedge clk);
        total++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            bad++;
            $display("FAIL drain queued got=%0d expected=0", q_a.size() + q_b.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
